regfile_test_access: RTL and testbench
======================================

REGFILE_TEST_ACCESS -- requirements
Module: regfile_test_access

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  DATA_WIDTH  32  register data width.
  ADDR_WIDTH  5  register address width; 2**ADDR_WIDTH registers.
  NUM_CH  2  number of test channels (1..8).
REQ-002 Ports, one per line: name, direction, width, meaning.
  clock  in  1  single clock; all state updates on its rising edge.
  reset  in  1  synchronous, active-high.
  core_step  in  1  processor is at an instruction boundary this cycle.
  core_stall  out  1  holds the processor.
  c_we, c_waddr, c_raddr_a, c_raddr_b, c_wdata  in  1/AW/AW/AW/DW  processor-side regfile controls.
  r_we, r_waddr, r_raddr_a, r_raddr_b, r_wdata  out  1/AW/AW/AW/DW  regfile-side controls.
  r_rdata_a  in  DW  regfile port-A read data, combinational from r_raddr_a.
  t_req, t_we, t_dump  in  NUM_CH each  per-channel request, write, dump flags.
  t_addr  in  NUM_CH*AW  per-channel address; t_wdata  in  NUM_CH*DW  per-channel write data.
  t_ack  out  NUM_CH  one-cycle completion pulse; t_rdata  out  DW  read/last result.
  d_valid  out  1; d_ready  in  1; d_addr  out  AW; d_data  out  DW  dump stream.

Function
REQ-003 The block SHALL implement states CORE, WAIT, GRANT, DUMP, ACK.
REQ-004 In CORE and WAIT, r_* SHALL equal c_* combinationally; in all other states r_* SHALL be driven by the block.
REQ-005 In CORE, with any t_req high, the block SHALL latch a winner by round-robin (search starts at last winner+1, mod NUM_CH) and enter WAIT.
REQ-006 core_stall SHALL be 1 in WAIT, GRANT, DUMP, ACK and 0 in CORE.
REQ-007 WAIT SHALL go to GRANT on the first cycle core_step=1; if the winner's t_req drops first, it SHALL return to CORE with no t_ack.
REQ-008 GRANT (one cycle), write: r_we=1, r_waddr=t_addr[win], r_wdata=t_wdata[win]; address 0 SHALL give r_we=0 but still be acknowledged.
REQ-009 GRANT, read: r_raddr_a=t_addr[win]; t_rdata SHALL register r_rdata_a at the end of that cycle.
REQ-010 GRANT with t_dump[win]=1 SHALL enter DUMP (t_dump takes priority over t_we).
REQ-011 DUMP: d_valid=1, d_addr=counter, r_raddr_a=counter, d_data=r_rdata_a; the counter advances only on d_valid&d_ready.
REQ-012 DUMP SHALL hold all outputs stable while d_ready=0 and SHALL go to ACK after the handshake at address 2**AW-1.
REQ-013 ACK: t_ack[win]=1 for exactly one cycle, all other t_ack=0; the next state SHALL always be CORE, giving the core at least one cycle between test transactions.
REQ-014 t_req[win] SHALL NOT be re-sampled in the ACK cycle; the requester drops t_req after t_ack.
REQ-015 Minimum latency: t_req at cycle n with core_step=1 gives WAIT n+1, GRANT n+2, t_ack and valid t_rdata at n+3.
REQ-016 r_we SHALL never be 1 in WAIT, DUMP or ACK from a test source; r_raddr_b SHALL pass c_raddr_b in every state.

Reset
REQ-017 reset SHALL force state CORE, the round-robin pointer to 0 (channel 0 has first priority), and the dump counter to 0.
REQ-018 During and after reset: core_stall=0, t_ack=0, t_rdata=0, d_valid=0, d_addr=0; r_* SHALL mirror c_*.
REQ-019 reset mid-transaction SHALL abort it with no t_ack and no further test write.

Structure
REQ-020 Package regfile_test_pkg SHALL hold the state encoding and the default DATA_WIDTH, ADDR_WIDTH and NUM_CH constants.
REQ-021 Round-robin selection SHALL be a sub-module rr_arbiter (NUM_CH parameter; req vector in; one-hot grant out; pointer update on an enable input).

Verification
REQ-022 Ch0 write: addr 5, data 0xDEADBEEF, core_step=1 -> r_we=1 with r_waddr=5 at n+2; t_ack[0] at n+3; then a read of 5 returns t_rdata=0xDEADBEEF.
REQ-023 Ch0 and ch1 request in the same cycle after reset -> ch0 served first, then CORE for at least 1 cycle, then ch1; the next tie goes to ch1 after ch0.
REQ-024 Request with core_step=0 for 4 cycles -> WAIT held, core_stall=1, c_we passes to r_we; GRANT on the cycle after core_step=1.
REQ-025 Ch1 write to addr 0 with data 0x1234 -> r_we stays 0, t_ack[1] still pulses, and a read of 0 returns 0.
REQ-026 Dump with d_ready toggled 1,0,0,1,... -> 32 handshakes, d_addr 0..31 in order with no repeat or skip, t_ack once after addr 31.
REQ-027 reset asserted in DUMP at d_addr=7 -> next cycle CORE, d_valid=0, no t_ack, core_stall=0.

Source files
------------

// File: rtl/regfile_test_pkg.sv
// Shared constants for the register-file test access block: default sizes
// and the controller state encoding.
package regfile_test_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned ADDR_WIDTH_DEF = 5;
    localparam int unsigned NUM_CH_DEF     = 2;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_CORE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_WAIT  = 3'd1;
    localparam logic [STATE_W-1:0] ST_GRANT = 3'd2;
    localparam logic [STATE_W-1:0] ST_DUMP  = 3'd3;
    localparam logic [STATE_W-1:0] ST_ACK   = 3'd4;

    // The processor is held in every state except CORE.
    function automatic logic state_stalls(input logic [STATE_W-1:0] st);
        return st != ST_CORE;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at the channel after the
// last winner; the pointer only moves when en_i is high and a request exists.
module rr_arbiter #(
    parameter int unsigned NUM_CH = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [NUM_CH-1:0] req_i,
    output logic [NUM_CH-1:0] grant_o
);

    localparam int unsigned IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [IW-1:0] ptr_q, ptr_d;
    logic          found;
    int unsigned   idx;

    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = (32'(ptr_q) + k) % NUM_CH;
            if (!found && req_i[IW'(idx)]) begin
                grant_o[IW'(idx)] = 1'b1;
                found             = 1'b1;
                ptr_d             = IW'((idx + 1) % NUM_CH);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (en_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_test_access.sv
// Test access port into a processor register file: arbitrates test channels,
// steals the regfile ports at an instruction boundary and streams full dumps.
module regfile_test_access
    import regfile_test_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned NUM_CH     = NUM_CH_DEF
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         core_step,
    output logic                         core_stall,
    input  logic                         c_we,
    input  logic [ADDR_WIDTH-1:0]        c_waddr,
    input  logic [ADDR_WIDTH-1:0]        c_raddr_a,
    input  logic [ADDR_WIDTH-1:0]        c_raddr_b,
    input  logic [DATA_WIDTH-1:0]        c_wdata,
    output logic                         r_we,
    output logic [ADDR_WIDTH-1:0]        r_waddr,
    output logic [ADDR_WIDTH-1:0]        r_raddr_a,
    output logic [ADDR_WIDTH-1:0]        r_raddr_b,
    output logic [DATA_WIDTH-1:0]        r_wdata,
    input  logic [DATA_WIDTH-1:0]        r_rdata_a,
    input  logic [NUM_CH-1:0]            t_req,
    input  logic [NUM_CH-1:0]            t_we,
    input  logic [NUM_CH-1:0]            t_dump,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] t_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] t_wdata,
    output logic [NUM_CH-1:0]            t_ack,
    output logic [DATA_WIDTH-1:0]        t_rdata,
    output logic                         d_valid,
    input  logic                         d_ready,
    output logic [ADDR_WIDTH-1:0]        d_addr,
    output logic [DATA_WIDTH-1:0]        d_data
);

    localparam int unsigned IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    logic [STATE_W-1:0]    state_q, state_d;
    logic [STATE_W-1:0]    st;
    logic [IW-1:0]         win_q, win_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [NUM_CH-1:0]     grant;
    logic [IW-1:0]         grant_idx;
    logic                  sel_req, sel_we, sel_dump;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Reset acts on the outputs in the same cycle so an aborted transaction
    // can neither write nor acknowledge while reset is still high.
    assign st = reset ? ST_CORE : state_q;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk_i   (clock),
        .rst_i   (reset),
        .en_i    (st == ST_CORE),
        .req_i   (t_req),
        .grant_o (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            if (grant[IW'(ch)]) begin
                grant_idx = IW'(ch);
            end
        end
    end

    // Latched winner's request fields.
    always_comb begin
        sel_req   = 1'b0;
        sel_we    = 1'b0;
        sel_dump  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            if (win_q == IW'(ch)) begin
                sel_req   = t_req[IW'(ch)];
                sel_we    = t_we[IW'(ch)];
                sel_dump  = t_dump[IW'(ch)];
                sel_addr  = t_addr[ch*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = t_wdata[ch*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        r_we       = c_we;
        r_waddr    = c_waddr;
        r_raddr_a  = c_raddr_a;
        r_raddr_b  = c_raddr_b;
        r_wdata    = c_wdata;
        t_ack      = '0;
        d_valid    = 1'b0;
        d_data     = '0;
        core_stall = state_stalls(st);

        case (st)
            ST_CORE: begin
                if (|t_req) begin
                    state_d = ST_WAIT;
                    win_d   = grant_idx;
                end
            end
            ST_WAIT: begin
                if (!sel_req) begin
                    state_d = ST_CORE;
                end else if (core_step) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Register 0 is hard-wired; writes to it are dropped but acked.
                r_we      = sel_we && !sel_dump && (sel_addr != '0);
                r_waddr   = sel_addr;
                r_raddr_a = sel_addr;
                r_wdata   = sel_wdata;
                if (sel_dump) begin
                    state_d = ST_DUMP;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_ACK;
                    if (!sel_we) begin
                        rdata_d = r_rdata_a;
                    end
                end
            end
            ST_DUMP: begin
                r_we      = 1'b0;
                r_waddr   = '0;
                r_wdata   = '0;
                r_raddr_a = cnt_q;
                d_valid   = 1'b1;
                d_data    = r_rdata_a;
                if (d_ready) begin
                    if (cnt_q == LAST_ADDR) begin
                        state_d = ST_ACK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ADDR_WIDTH'(1);
                    end
                end
            end
            ST_ACK: begin
                r_we      = 1'b0;
                r_waddr   = '0;
                r_wdata   = '0;
                r_raddr_a = '0;
                t_ack     = NUM_CH'(1) << win_q;
                state_d   = ST_CORE;
            end
            default: begin
                state_d = ST_CORE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_CORE;
            win_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    assign d_addr  = reset ? '0 : cnt_q;
    assign t_rdata = reset ? '0 : rdata_q;

endmodule

// File: tb/tb_regfile_test_access.sv
// Bench for regfile_test_access: directed scenarios plus random transactions
// against a transaction-level model (round-robin pointer and register image).
module tb_regfile_test_access;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NCH  = 2;
    localparam int unsigned IW   = 1;
    localparam int unsigned NREG = 32;

    logic            clock = 1'b0;
    logic            reset;
    logic            core_step;
    logic            core_stall;
    logic            c_we;
    logic [AW-1:0]   c_waddr, c_raddr_a, c_raddr_b;
    logic [DW-1:0]   c_wdata;
    logic            r_we;
    logic [AW-1:0]   r_waddr, r_raddr_a, r_raddr_b;
    logic [DW-1:0]   r_wdata, r_rdata_a;
    logic [NCH-1:0]  t_req, t_we, t_dump, t_ack;
    logic [NCH*AW-1:0] t_addr;
    logic [NCH*DW-1:0] t_wdata;
    logic [DW-1:0]   t_rdata;
    logic            d_valid, d_ready;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_data;

    logic            mem_clr;
    logic [DW-1:0]   mem     [NREG];
    logic [DW-1:0]   exp_mem [NREG];
    int              rr_ptr;
    int              n_checks;
    int              n_fail;

    always #5 clock = ~clock;

    regfile_test_access #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_CH     (NCH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .core_step  (core_step),
        .core_stall (core_stall),
        .c_we       (c_we),
        .c_waddr    (c_waddr),
        .c_raddr_a  (c_raddr_a),
        .c_raddr_b  (c_raddr_b),
        .c_wdata    (c_wdata),
        .r_we       (r_we),
        .r_waddr    (r_waddr),
        .r_raddr_a  (r_raddr_a),
        .r_raddr_b  (r_raddr_b),
        .r_wdata    (r_wdata),
        .r_rdata_a  (r_rdata_a),
        .t_req      (t_req),
        .t_we       (t_we),
        .t_dump     (t_dump),
        .t_addr     (t_addr),
        .t_wdata    (t_wdata),
        .t_ack      (t_ack),
        .t_rdata    (t_rdata),
        .d_valid    (d_valid),
        .d_ready    (d_ready),
        .d_addr     (d_addr),
        .d_data     (d_data)
    );

    // Register file attached to the r_* side; register 0 reads as zero.
    assign r_rdata_a = mem[r_raddr_a];
    always @(posedge clock) begin
        if (mem_clr) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (r_we && r_waddr != '0) begin
            mem[r_waddr] <= r_wdata;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] r_bus();
        return 64'({r_we, r_waddr, r_raddr_a, r_wdata});
    endfunction

    function automatic logic [63:0] c_bus();
        return 64'({c_we, c_waddr, c_raddr_a, c_wdata});
    endfunction

    // Core writes only target register 0 so they never disturb the image.
    task automatic rand_core();
        c_we      = 1'($urandom_range(0, 1));
        c_waddr   = c_we ? '0 : AW'($urandom);
        c_raddr_a = AW'($urandom);
        c_raddr_b = AW'($urandom);
        c_wdata   = $urandom;
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
        rand_core();
    endtask

    task automatic settle();
        #1;
        check("raddr_b_pass", 64'(r_raddr_b), 64'(c_raddr_b));
    endtask

    function automatic int pick(input logic [NCH-1:0] m);
        for (int k = 0; k < NCH; k++) begin
            if (m[IW'((rr_ptr + k) % NCH)]) return (rr_ptr + k) % NCH;
        end
        return 0;
    endfunction

    task automatic set_ch(input int ch, input logic we, input logic dump,
                          input logic [AW-1:0] addr, input logic [DW-1:0] data);
        t_we[IW'(ch)]          = we;
        t_dump[IW'(ch)]        = dump;
        t_addr[ch*AW +: AW]    = addr;
        t_wdata[ch*DW +: DW]   = data;
    endtask

    // Runs one transaction from a CORE cycle; returns in the following CORE cycle.
    task automatic serve(input logic [NCH-1:0] mask, input int delay, input logic [3:0] dpat,
                         output int w, output logic [NCH-1:0] ack_obs);
        logic          w_we, w_dump;
        logic [AW-1:0] w_addr;
        logic [DW-1:0] w_wdata, exp_rd;
        int            cnt;
        w       = pick(mask);
        rr_ptr  = (w + 1) % NCH;
        w_we    = t_we[IW'(w)];
        w_dump  = t_dump[IW'(w)];
        w_addr  = t_addr[w*AW +: AW];
        w_wdata = t_wdata[w*DW +: DW];
        exp_rd  = exp_mem[w_addr];
        cnt     = 0;

        t_req = mask;
        core_step = (delay == 0);
        settle();
        check("core_stall_core", 64'(core_stall), 64'(0));
        check("pass_core", r_bus(), c_bus());
        adv();
        for (int d = 0; d < delay; d++) begin
            core_step = 1'b0;
            settle();
            check("wait_stall", 64'(core_stall), 64'(1));
            check("pass_wait", r_bus(), c_bus());
            adv();
        end
        core_step = 1'b1;
        settle();
        check("wait_stall", 64'(core_stall), 64'(1));
        check("pass_wait", r_bus(), c_bus());
        adv();

        core_step = 1'b0;
        settle();
        check("grant_stall", 64'(core_stall), 64'(1));
        check("grant_we", 64'(r_we), 64'(w_we && !w_dump && (w_addr != '0)));
        check("grant_ack", 64'(t_ack), 64'(0));
        if (!w_dump && w_we) begin
            check("grant_waddr", 64'(r_waddr), 64'(w_addr));
            check("grant_wdata", 64'(r_wdata), 64'(w_wdata));
            if (w_addr != '0) exp_mem[w_addr] = w_wdata;
        end
        if (!w_dump && !w_we) check("grant_raddr", 64'(r_raddr_a), 64'(w_addr));
        adv();

        if (w_dump) begin
            for (int i = 0; i < 256 && cnt < NREG; i++) begin
                d_ready = dpat[2'(i % 4)];
                settle();
                check("dump_valid", 64'(d_valid), 64'(1));
                check("dump_addr", 64'(d_addr), 64'(cnt));
                check("dump_data", 64'(d_data), 64'(exp_mem[AW'(cnt)]));
                check("dump_we", 64'(r_we), 64'(0));
                check("dump_ack", 64'(t_ack), 64'(0));
                if (d_ready) cnt++;
                adv();
            end
            d_ready = 1'b0;
            if (cnt < NREG) check("dump_budget", 64'(cnt), 64'(NREG));
        end

        settle();
        ack_obs = t_ack;
        check("ack_vec", 64'(t_ack), 64'(NCH'(1) << w));
        check("ack_we", 64'(r_we), 64'(0));
        check("ack_dvalid", 64'(d_valid), 64'(0));
        check("ack_stall", 64'(core_stall), 64'(1));
        if (!w_we && !w_dump) check("ack_rdata", 64'(t_rdata), 64'(exp_rd));
        t_req[IW'(w)] = 1'b0;
        adv();
        settle();
        check("post_ack_core", 64'({t_ack, core_stall}), 64'(0));
    endtask

    // Request then withdraw while waiting for an instruction boundary.
    task automatic abort_txn(input int ch);
        logic [NCH-1:0] m;
        m = '0;
        m[IW'(ch)] = 1'b1;
        rr_ptr = (pick(m) + 1) % NCH;
        t_req = m;
        core_step = 1'b0;
        settle();
        check("abort_core", 64'(core_stall), 64'(0));
        adv();
        settle();
        check("abort_wait", 64'(core_stall), 64'(1));
        t_req = '0;
        adv();
        settle();
        check("abort_back", 64'({t_ack, core_stall}), 64'(0));
        adv();
        settle();
        check("abort_noack", 64'({t_ack, core_stall}), 64'(0));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int             w;
        logic [NCH-1:0] ack, mask;
        logic           hit;
        n_checks = 0;
        n_fail   = 0;
        rr_ptr   = 0;
        reset = 1'b1; mem_clr = 1'b1; core_step = 1'b0; d_ready = 1'b0;
        t_req = '0; t_we = '0; t_dump = '0; t_addr = '0; t_wdata = '0;
        for (int i = 0; i < NREG; i++) exp_mem[i] = '0;
        rand_core();

        // Reset values, during and after reset
        settle();
        check("rst_outs", 64'({core_stall, t_ack, d_valid, d_addr}), 64'(0));
        check("rst_rdata", 64'(t_rdata), 64'(0));
        check("rst_pass", r_bus(), c_bus());
        adv(); adv();
        reset = 1'b0; mem_clr = 1'b0;
        settle();
        check("post_rst_outs", 64'({core_stall, t_ack, d_valid, d_addr}), 64'(0));
        check("post_rst_rdata", 64'(t_rdata), 64'(0));
        check("post_rst_pass", r_bus(), c_bus());

        // Channel 0 write then read back
        set_ch(0, 1'b1, 1'b0, AW'(5), 32'hDEADBEEF);
        serve(2'b01, 0, 4'hF, w, ack);
        check("wr5_ack", 64'(ack), 64'(2'b01));
        set_ch(0, 1'b0, 1'b0, AW'(5), '0);
        serve(2'b01, 0, 4'hF, w, ack);
        settle();
        check("rd5_rdata", 64'(t_rdata), 64'(32'hDEADBEEF));

        // Tie right after reset: ch0, then ch1, then ch0 again wins the next tie
        reset = 1'b1; t_req = '0; adv(); adv();
        reset = 1'b0; rr_ptr = 0;
        set_ch(0, 1'b1, 1'b0, AW'(3), 32'h3333_0000);
        set_ch(1, 1'b1, 1'b0, AW'(4), 32'h0000_4444);
        serve(2'b11, 0, 4'hF, w, ack);
        check("tie1_first", 64'(ack), 64'(2'b01));
        serve(2'b10, 0, 4'hF, w, ack);
        check("tie1_second", 64'(ack), 64'(2'b10));
        serve(2'b11, 0, 4'hF, w, ack);
        check("tie2_first", 64'(ack), 64'(2'b01));
        serve(2'b10, 0, 4'hF, w, ack);
        check("tie2_second", 64'(ack), 64'(2'b10));

        // Long wait for an instruction boundary
        set_ch(0, 1'b0, 1'b0, AW'(3), '0);
        serve(2'b01, 4, 4'hF, w, ack);

        // Write to register 0 is dropped but acknowledged
        set_ch(1, 1'b1, 1'b0, AW'(0), 32'h0000_1234);
        serve(2'b10, 0, 4'hF, w, ack);
        check("wr0_ack", 64'(ack), 64'(2'b10));
        set_ch(1, 1'b0, 1'b0, AW'(0), '0);
        serve(2'b10, 1, 4'hF, w, ack);
        settle();
        check("rd0_rdata", 64'(t_rdata), 64'(0));

        // Full dump with d_ready 1,0,0,1,...
        set_ch(0, 1'b1, 1'b1, AW'(9), 32'hFFFF_FFFF);
        serve(2'b01, 0, 4'b1001, w, ack);
        check("dump_ack_once", 64'(ack), 64'(2'b01));

        // Withdrawn request still moves the pointer
        abort_txn(0);
        set_ch(0, 1'b0, 1'b0, AW'(4), '0);
        set_ch(1, 1'b0, 1'b0, AW'(3), '0);
        serve(2'b11, 2, 4'hF, w, ack);
        check("after_abort_tie", 64'(ack), 64'(2'b10));
        serve(2'b01, 0, 4'hF, w, ack);

        // Random traffic
        for (int r = 0; r < 30; r++) begin
            mask = NCH'($urandom_range(1, 3));
            for (int ch = 0; ch < NCH; ch++) begin
                set_ch(ch, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                       ($urandom_range(0, 5) == 0) ? AW'(0) : AW'($urandom), $urandom);
            end
            while (mask != '0) begin
                serve(mask, int'($urandom_range(0, 3)), 4'($urandom_range(1, 15)), w, ack);
                mask[IW'(w)] = 1'b0;
            end
            repeat ($urandom_range(0, 2)) begin
                adv();
                settle();
                check("idle_core", 64'({t_ack, core_stall}), 64'(0));
            end
        end

        // Reset in the middle of a dump
        set_ch(0, 1'b0, 1'b1, AW'(0), '0);
        rr_ptr = (pick(2'b01) + 1) % NCH;
        t_req = 2'b01;
        core_step = 1'b1;
        settle(); adv(); settle(); adv(); settle(); adv();
        d_ready = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 64 && !hit; i++) begin
            settle();
            if (d_valid && d_addr == AW'(7)) hit = 1'b1;
            else adv();
        end
        check("reach_addr7", 64'(hit), 64'(1));
        reset = 1'b1;
        t_req = '0;
        d_ready = 1'b0;
        settle();
        check("midrst_outs", 64'({core_stall, t_ack, d_valid, d_addr}), 64'(0));
        check("midrst_pass", r_bus(), c_bus());
        adv();
        reset = 1'b0;
        rr_ptr = 0;
        settle();
        check("after_midrst", 64'({core_stall, t_ack, d_valid, d_addr}), 64'(0));
        check("after_midrst_rdata", 64'(t_rdata), 64'(0));
        check("after_midrst_pass", r_bus(), c_bus());
        for (int i = 0; i < 3; i++) begin
            adv();
            settle();
            check("after_midrst_noack", 64'({t_ack, core_stall}), 64'(0));
        end
        set_ch(0, 1'b0, 1'b0, AW'(4), '0);
        set_ch(1, 1'b0, 1'b0, AW'(5), '0);
        serve(2'b11, 0, 4'hF, w, ack);
        check("ptr_reset_tie", 64'(ack), 64'(2'b01));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
